// File: rtl/count_seq_checker.sv
// Checks that an upstream 3-bit counter increments by one each valid sample; locks after
// LOCK_THRESH good steps and counts mismatches. Define COUNT_SEQ_WRAP_CNT_EN for wrap_count.
module count_seq_checker #(
   parameter int unsigned ERR_W       = 8,
   parameter int unsigned LOCK_THRESH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       count_in,
   input  logic             count_valid,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic [7:0]       wrap_count,
   output logic [2:0]       last_value,
   output logic [2:0]       expected
);

   typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

   state_e           r_state, w_state_d;
   logic [2:0]       r_good_run, w_good_run_d;
   logic [2:0]       r_last_value;
   logic             r_err_pulse, w_err_pulse_d;
   logic [ERR_W-1:0] r_err_count, w_err_count_d;
   logic             w_good;
   logic             w_err_inc;
   logic [3:0]       w_run_inc;

   assign expected   = r_last_value + 3'd1;
   assign w_good     = (count_in == expected);
   assign w_run_inc  = {1'b0, r_good_run} + 4'd1;
   assign locked     = (r_state == StLocked);
   assign err_pulse  = r_err_pulse;
   assign err_count  = r_err_count;
   assign last_value = r_last_value;

   always_comb begin
      w_state_d     = r_state;
      w_good_run_d  = r_good_run;
      w_err_pulse_d = 1'b0;
      w_err_inc     = 1'b0;
      if (count_valid) begin
         unique case (r_state)
            StIdle: begin
               w_state_d    = StAcquire;
               w_good_run_d = 3'd0;
            end
            StAcquire: begin
               if (w_good) begin
                  w_good_run_d = w_run_inc[2:0];
                  if (w_run_inc >= 4'(LOCK_THRESH)) begin
                     w_state_d = StLocked;
                  end
               end else begin
                  w_good_run_d = 3'd0;
               end
            end
            StLocked: begin
               if (!w_good) begin
                  w_state_d     = StAcquire;
                  w_good_run_d  = 3'd0;
                  w_err_pulse_d = 1'b1;
                  w_err_inc     = 1'b1;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   // Clear wins over a same-cycle increment; the count sticks at all-ones.
   always_comb begin
      w_err_count_d = r_err_count;
      if (clear) begin
         w_err_count_d = '0;
      end else if (w_err_inc && (r_err_count != {ERR_W{1'b1}})) begin
         w_err_count_d = r_err_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= StIdle;
         r_good_run   <= 3'd0;
         r_last_value <= 3'd0;
         r_err_pulse  <= 1'b0;
         r_err_count  <= '0;
      end else begin
         r_state     <= w_state_d;
         r_good_run  <= w_good_run_d;
         r_err_pulse <= w_err_pulse_d;
         r_err_count <= w_err_count_d;
         if (count_valid) begin
            r_last_value <= count_in;
         end
      end
   end

`ifdef COUNT_SEQ_WRAP_CNT_EN
   logic [7:0] r_wrap_count;
   logic       w_wrap_inc;

   // Only a good 7->0 step seen while already locked counts as a wrap.
   assign w_wrap_inc = count_valid && (r_state == StLocked) && w_good && (count_in == 3'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrap_count <= 8'd0;
      end else if (clear) begin
         r_wrap_count <= 8'd0;
      end else if (w_wrap_inc) begin
         r_wrap_count <= r_wrap_count + 8'd1;
      end
   end

   assign wrap_count = r_wrap_count;
`else
   assign wrap_count = 8'd0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed, table-driven bench for count_seq_checker (LOCK_THRESH=2, ERR_W=8).
module tb_count_seq_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] count_in = 3'd0;
   logic       count_valid = 1'b0;
   logic       clear = 1'b0;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_count;
   logic [7:0] wrap_count;
   logic [2:0] last_value;
   logic [2:0] expected;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef COUNT_SEQ_WRAP_CNT_EN
   localparam logic [7:0] W1 = 8'd1;
`else
   localparam logic [7:0] W1 = 8'd0;
`endif

   typedef struct {
      logic       rst;
      logic       vld;
      logic [2:0] cnt;
      logic       clr;
      logic       e_lock;
      logic       e_pulse;
      logic [7:0] e_err;
      logic [7:0] e_wrap;
      logic [2:0] e_last;
   } vec_t;

   vec_t vecs[$];

   count_seq_checker #(
      .ERR_W       (8),
      .LOCK_THRESH (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .count_in    (count_in),
      .count_valid (count_valid),
      .clear       (clear),
      .locked      (locked),
      .err_pulse   (err_pulse),
      .err_count   (err_count),
      .wrap_count  (wrap_count),
      .last_value  (last_value),
      .expected    (expected)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic vld, input logic [2:0] cnt, input logic clr,
                      input logic el, input logic ep, input logic [7:0] ee, input logic [7:0] ew,
                      input logic [2:0] elast);
      vec_t v;
      v = '{rst, vld, cnt, clr, el, ep, ee, ew, elast};
      vecs.push_back(v);
   endtask

   task automatic step(input logic rst, input logic vld, input logic [2:0] cnt,
                       input logic clr);
      reset       = rst;
      count_valid = vld;
      count_in    = cnt;
      clear       = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input vec_t v);
      logic [2:0] e_exp;
      e_exp = v.e_last + 3'd1;
      check({tag, " locked"}, 32'(locked), 32'(v.e_lock));
      check({tag, " err_pulse"}, 32'(err_pulse), 32'(v.e_pulse));
      check({tag, " err_count"}, 32'(err_count), 32'(v.e_err));
      check({tag, " wrap_count"}, 32'(wrap_count), 32'(v.e_wrap));
      check({tag, " last_value"}, 32'(last_value), 32'(v.e_last));
      check({tag, " expected"}, 32'(expected), 32'(e_exp));
   endtask

   initial begin
      logic [2:0] lv;
      logic [7:0] model_err;

      //   rst vld cnt clr  lock pulse err    wrap   last
      add(1, 0, 0, 0,  0, 0, 8'd0, 8'd0, 0);   // reset: expected reads 1
      add(0, 1, 3, 0,  0, 0, 8'd0, 8'd0, 3);   // lock sequence 3,4,5
      add(0, 1, 4, 0,  0, 0, 8'd0, 8'd0, 4);
      add(0, 1, 5, 0,  1, 0, 8'd0, 8'd0, 5);
      add(0, 1, 6, 0,  1, 0, 8'd0, 8'd0, 6);   // wrap 6,7,0,1
      add(0, 1, 7, 0,  1, 0, 8'd0, 8'd0, 7);
      add(0, 1, 0, 0,  1, 0, 8'd0, W1,   0);
      add(0, 1, 1, 0,  1, 0, 8'd0, W1,   1);
      add(0, 1, 2, 0,  1, 0, 8'd0, W1,   2);
      add(0, 1, 5, 0,  0, 1, 8'd1, W1,   5);   // mismatch at last=2
      add(0, 1, 6, 0,  0, 0, 8'd1, W1,   6);
      add(0, 1, 7, 0,  1, 0, 8'd1, W1,   7);   // relocked
      add(0, 0, 0, 1,  1, 0, 8'd0, 8'd0, 7);   // clear, FSM untouched
      add(0, 0, 5, 0,  1, 0, 8'd0, 8'd0, 7);   // invalid sample ignored
      add(1, 1, 3, 0,  0, 0, 8'd0, 8'd0, 0);   // reset mid-lock overrides valid
      add(0, 1, 0, 0,  0, 0, 8'd0, 8'd0, 0);   // 0 in IDLE/ACQUIRE is no wrap
      add(0, 1, 1, 0,  0, 0, 8'd0, 8'd0, 1);
      add(0, 1, 2, 0,  1, 0, 8'd0, 8'd0, 2);
      add(1, 0, 0, 0,  0, 0, 8'd0, 8'd0, 0);
      add(0, 1, 1, 0,  0, 0, 8'd0, 8'd0, 1);   // valid gaps
      add(0, 0, 7, 0,  0, 0, 8'd0, 8'd0, 1);
      add(0, 0, 7, 0,  0, 0, 8'd0, 8'd0, 1);
      add(0, 0, 7, 0,  0, 0, 8'd0, 8'd0, 1);
      add(0, 1, 2, 0,  0, 0, 8'd0, 8'd0, 2);
      add(0, 1, 3, 0,  1, 0, 8'd0, 8'd0, 3);
      add(1, 0, 0, 0,  0, 0, 8'd0, 8'd0, 0);
      add(0, 1, 4, 0,  0, 0, 8'd0, 8'd0, 4);   // bad in ACQUIRE restarts run
      add(0, 1, 5, 0,  0, 0, 8'd0, 8'd0, 5);
      add(0, 1, 7, 0,  0, 0, 8'd0, 8'd0, 7);
      add(0, 1, 0, 0,  0, 0, 8'd0, 8'd0, 0);
      add(0, 1, 1, 0,  1, 0, 8'd0, 8'd0, 1);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].vld, vecs[i].cnt, vecs[i].clr);
         check_all($sformatf("row%0d", i), vecs[i]);
      end

      // Saturation: 300 locked mismatches, relocking after each.
      lv        = 3'd1;
      model_err = 8'd0;
      for (int k = 0; k < 300; k++) begin
         lv = lv + 3'd3;
         step(0, 1, lv, 0);
         if (model_err != 8'hff) model_err = model_err + 8'd1;
         check($sformatf("sat%0d err_pulse", k), 32'(err_pulse), 32'd1);
         check($sformatf("sat%0d err_count", k), 32'(err_count), 32'(model_err));
         lv = lv + 3'd1;
         step(0, 1, lv, 0);
         lv = lv + 3'd1;
         step(0, 1, lv, 0);
         check($sformatf("sat%0d relock", k), 32'(locked), 32'd1);
      end
      check("sat final err_count", 32'(err_count), 32'd255);

      // Clear together with a mismatch: clear wins, pulse still fires.
      lv = lv + 3'd3;
      step(0, 1, lv, 1);
      check("clr+mis err_count", 32'(err_count), 32'd0);
      check("clr+mis err_pulse", 32'(err_pulse), 32'd1);
      check("clr+mis locked", 32'(locked), 32'd0);
      step(0, 0, 0, 0);
      check("pulse one cycle", 32'(err_pulse), 32'd0);
      check("hold last_value", 32'(last_value), 32'(lv));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
